// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Arbitrates a fetch port and a data (load/store) port onto a single-port
//   memory bus.
//
//   Rules:
//     - At most one memory transaction is outstanding at a time.
//     - Grants are combinational. They are issued in IDLE, or in the cycle
//       that the outstanding transaction completes (mem_rvalid), so
//       back-to-back transactions run without a bubble.
//     - The data port has priority over the fetch port.
//
//   Optional macro MEM_ARB_STARVE_GUARD_EN:
//     Adds a starvation counter. When fetch has been denied STARVE_MAX
//     consecutive arbitrations, fetch is forced to win the next one.
//
//   Parameters:
//     ADDR_W      memory address width
//     DATA_W      memory data width
//     STARVE_MAX  denied-fetch arbitrations that force a fetch grant
//                 (guard build only)
//
//   Ports:
//     clk, reset                                clock, async active-high reset
//     if_req, if_addr                           fetch read request
//     if_gnt, if_rvalid, if_rdata               fetch grant / response
//     d_req, d_we, d_addr, d_wdata              data request (d_we=1 is a store)
//     d_gnt, d_rvalid, d_rdata                  data grant / response or store ack
//     mem_req, mem_we, mem_addr, mem_wdata      memory request bus
//     mem_rvalid, mem_rdata                     memory response
//     stall                                     a request is pending without a grant
module mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall
);

  if (STARVE_MAX < 1) begin : g_bad_starve_max
    $error("mem_arbiter: STARVE_MAX must be at least 1");
  end

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_D  = 2'd2
  } state_t;

  state_t state, state_nxt;
  logic   arb;
  logic   gnt_if;
  logic   gnt_d;
  logic   force_if;

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0] starve_cnt;

  assign force_if = (starve_cnt == CNT_MAX);

  // Counts consecutive arbitrations in which fetch was waiting but data won.
  // Any fetch grant, or fetch going away, restarts the count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (gnt_if || !if_req) begin
      starve_cnt <= '0;
    end else if (arb && gnt_d && (starve_cnt != CNT_MAX)) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end
`else
  assign force_if = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Arbitration happens when idle, or when the outstanding transaction
  // completes this cycle. A stray mem_rvalid in IDLE needs no special
  // handling: IDLE is already an arbitration cycle, and the response
  // routing below only looks at mem_rvalid in the BUSY states.
  always_comb begin
    state_nxt = state;
    gnt_if    = 1'b0;
    gnt_d     = 1'b0;
    arb       = (state == IDLE) || mem_rvalid;
    if (arb) begin
      if (d_req && !(force_if && if_req)) begin
        gnt_d     = 1'b1;
        state_nxt = BUSY_D;
      end else if (if_req) begin
        gnt_if    = 1'b1;
        state_nxt = BUSY_IF;
      end else begin
        state_nxt = IDLE;
      end
    end
  end

  // While reset is high, every output is held at 0, including the read-data
  // pass-through.
  always_comb begin
    if_gnt    = 1'b0;
    d_gnt     = 1'b0;
    if_rvalid = 1'b0;
    d_rvalid  = 1'b0;
    if_rdata  = '0;
    d_rdata   = '0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    stall     = 1'b0;
    if (!reset) begin
      if_gnt    = gnt_if;
      d_gnt     = gnt_d;
      if_rvalid = (state == BUSY_IF) && mem_rvalid;
      d_rvalid  = (state == BUSY_D) && mem_rvalid;
      if_rdata  = mem_rdata;
      d_rdata   = mem_rdata;
      mem_req   = gnt_if || gnt_d;
      // Fetch transactions are always reads.
      mem_we    = gnt_d && d_we;
      if (gnt_d) begin
        mem_addr  = d_addr;
        mem_wdata = d_wdata;
      end else if (gnt_if) begin
        mem_addr  = if_addr;
      end
      stall     = (if_req && !gnt_if) || (d_req && !gnt_d);
    end
  end

endmodule
